decode_stage: RTL
=================

# decode_stage

Second pipeline stage of the RV32I core, directly downstream of instruction fetch. Captures fetch outputs (PC, PC+4, instruction) in an IF/ID pipeline register with stall and flush control, decodes the held instruction into register addresses, immediate and control bits, and detects load-use hazards. On a load-use hazard it holds itself and fetch, and emits a bubble toward execute.

## Interface
- XLEN, 32, datapath width; only 32 supported
- NOP_INSTR, 32'h0000_0013, encoding loaded on reset/flush (addi x0,x0,0)
- clk  in  1  rising-edge clock, sole clock
- rst  in  1  synchronous, active-high reset
- pc_if  in  32  PC of fetched instruction
- pc_plus_four_if  in  32  PC+4 from fetch
- instruction_if  in  32  fetched instruction word
- stall_id  in  1  external hold of IF/ID register
- flush_id  in  1  replace IF/ID contents with bubble (taken branch/jump)
- ex_mem_read  in  1  instruction currently in EX is a load
- ex_rd  in  5  destination register of instruction in EX
- stall_if  out  1  hold PC in fetch; = load_use_stall | stall_id
- valid_id  out  1  IF/ID holds a real instruction
- pc_id, pc_plus_four_id  out  32  registered PC / PC+4
- instr_id  out  32  registered instruction
- rs1, rs2, rd  out  5  register fields (zeroed when field unused by format)
- imm  out  32  sign-extended immediate (I/S/B/U/J)
- funct3  out  3  instruction funct3
- alu_ctrl  out  4  ALU operation code (package enum)
- alu_src_imm, reg_write, mem_read, mem_write, branch, jump, jalr  out  1 each  control bits
- wb_sel  out  2  0 ALU, 1 memory, 2 PC+4
- illegal  out  1  unsupported opcode (see Configuration)

## Operation
- IF/ID register update priority per clk edge: rst > flush_id > (stall_id | load_use_stall) hold > load.
- rst or flush_id: instr_id=NOP_INSTR, valid_id=0, pc_id=0, pc_plus_four_id=0.
- Load: capture pc_if, pc_plus_four_if, instruction_if; valid_id=1.
- Hold: all IF/ID fields keep value.
- Decode purely combinational from instr_id. Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- Immediates: I={20{i[31]},i[31:20]}; S={20{i[31]},i[31:25],i[11:7]}; B={19{i[31]},i[31],i[7],i[30:25],i[11:8],0}; U={i[31:12],12'b0}; J={11{i[31]},i[31],i[19:12],i[20],i[30:21],0}.
- load_use_stall = valid_id & ex_mem_read & (ex_rd!=0) & ((uses_rs1 & ex_rd==rs1) | (uses_rs2 & ex_rd==rs2)).
- When valid_id=0 or load_use_stall=1: reg_write, mem_read, mem_write, branch, jump, jalr all forced 0 (bubble to EX); illegal forced 0.
- flush_id simultaneous with load_use_stall: flush wins; register becomes bubble, stall drops next cycle.
- rd=0 writes: reg_write still follows opcode; register file discards x0.

## Timing
- Latency 1 cycle: instruction_if sampled at edge N appears decoded during cycle N+1.
- Hazard detection same-cycle combinational; stall_if asserted in the cycle the hazard exists, exactly 1 cycle per load-use (EX advances).
- All outputs after reset: valid_id=0, instr_id=0x00000013, pcs 0, controls 0, stall_if=stall_id.
- Reset mid-stall discards held instruction.

## Configuration
- DECODE_ILLEGAL_CHECK_EN defined: illegal=1 for valid, unstalled instr_id with unsupported opcode, or OP with funct7 not 0x00/0x20 (0x20 only for ADD/SUB, SRL/SRA); all controls forced 0 for it.
- Undefined: illegal tied 0; unsupported opcodes decode with all controls 0 (silent NOP).

## Structure
- Shared package riscv_pkg: opcode constants, NOP_INSTR, alu_ctrl enum, wb_sel encodings.
- One sub-module imm_gen (instruction -> imm per format); IF/ID register and hazard logic stay in decode_stage.

## Test plan
- Load 0x00510093 (addi x1,x2,5) -> next cycle rs1=2, rd=1, imm=5, alu_src_imm=1, reg_write=1, valid_id=1.
- Load 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, branch=1, reg_write=0.
- Load 0x123452B7 (lui x5,0x12345) -> imm=0x12345000, rd=5, reg_write=1.
- instr_id=0x00518233 (add x4,x3,x5), ex_mem_read=1, ex_rd=3 -> stall_if=1, controls 0, instr held one cycle; ex_rd=0 -> no stall.
- flush_id=1 together with stall_id=1 -> next cycle valid_id=0, instr_id=0x00000013.
- With DECODE_ILLEGAL_CHECK_EN, load 0x0000007F -> illegal=1, all controls 0; assert rst mid-operation -> valid_id=0 next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode constants (opcodes, bubble encoding,
// ALU operation codes, writeback select encodings).
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_ctrl_e;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // funct3 -> ALU op for OP / OP-IMM; alt selects SUB / SRA
    function automatic alu_ctrl_e alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended immediate selected by the instruction's opcode format.
// R-type and unsupported opcodes produce zero.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    // pick the immediate layout from the opcode
    always_comb begin
        case (instr[6:0])
            OPC_JALR, OPC_LOAD, OPC_OP_IMM:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = 32'b0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: IF/ID pipeline register, RV32I decode and load-use hazard
// detection. Optional macro DECODE_ILLEGAL_CHECK_EN enables flagging of
// unsupported opcodes and bad OP funct7 values; otherwise they decode as NOPs.
module decode_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_if,
    input  logic [31:0] pc_plus_four_if,
    input  logic [31:0] instruction_if,
    input  logic        stall_id,
    input  logic        flush_id,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    output logic        stall_if,
    output logic        valid_id,
    output logic [31:0] pc_id,
    output logic [31:0] pc_plus_four_id,
    output logic [31:0] instr_id,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic [2:0]  funct3,
    output logic [3:0]  alu_ctrl,
    output logic        alu_src_imm,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        jump,
    output logic        jalr,
    output logic [1:0]  wb_sel,
    output logic        illegal
);

    logic [6:0] opcode;
    logic       uses_rs1, uses_rs2, uses_rd;
    alu_ctrl_e  alu_raw;
    logic       src_raw, rw_raw, mr_raw, mw_raw, br_raw, j_raw, jalr_raw;
    logic [1:0] wb_raw;
    logic       illegal_raw;
    logic       load_use_stall;
    logic       kill;

    assign stall_if = load_use_stall | stall_id;

    // IF/ID register: reset > flush > hold > load
    always_ff @(posedge clk) begin
        if (rst || flush_id) begin
            valid_id        <= 1'b0;
            instr_id        <= NOP_INSTR;
            pc_id           <= 32'b0;
            pc_plus_four_id <= 32'b0;
        end else if (!stall_if) begin
            valid_id        <= 1'b1;
            instr_id        <= instruction_if;
            pc_id           <= pc_if;
            pc_plus_four_id <= pc_plus_four_if;
        end
    end

    assign opcode = instr_id[6:0];
    assign funct3 = instr_id[14:12];

    imm_gen u_imm_gen (
        .instr (instr_id),
        .imm   (imm)
    );

    // raw per-opcode control decode, before bubble suppression
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        uses_rd  = 1'b0;
        alu_raw  = ALU_ADD;
        src_raw  = 1'b0;
        rw_raw   = 1'b0;
        mr_raw   = 1'b0;
        mw_raw   = 1'b0;
        br_raw   = 1'b0;
        j_raw    = 1'b0;
        jalr_raw = 1'b0;
        wb_raw   = WB_ALU;
        case (opcode)
            OPC_LUI: begin
                uses_rd = 1'b1; alu_raw = ALU_PASS_B; src_raw = 1'b1; rw_raw = 1'b1;
            end
            OPC_AUIPC: begin
                uses_rd = 1'b1; src_raw = 1'b1; rw_raw = 1'b1;
            end
            OPC_JAL: begin
                uses_rd = 1'b1; src_raw = 1'b1; rw_raw = 1'b1; j_raw = 1'b1; wb_raw = WB_PC4;
            end
            OPC_JALR: begin
                uses_rs1 = 1'b1; uses_rd = 1'b1; src_raw = 1'b1; rw_raw = 1'b1;
                j_raw = 1'b1; jalr_raw = 1'b1; wb_raw = WB_PC4;
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; br_raw = 1'b1;
                // BEQ/BNE compare by subtract, signed/unsigned compares otherwise
                alu_raw = !funct3[2] ? ALU_SUB : (!funct3[1] ? ALU_SLT : ALU_SLTU);
            end
            OPC_LOAD: begin
                uses_rs1 = 1'b1; uses_rd = 1'b1; src_raw = 1'b1; rw_raw = 1'b1;
                mr_raw = 1'b1; wb_raw = WB_MEM;
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; src_raw = 1'b1; mw_raw = 1'b1;
            end
            OPC_OP_IMM: begin
                uses_rs1 = 1'b1; uses_rd = 1'b1; src_raw = 1'b1; rw_raw = 1'b1;
                // only SRAI uses bit 30; ADDI has no subtract form
                alu_raw = alu_op(funct3, (funct3 == 3'b101) && instr_id[30]);
            end
            OPC_OP: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; uses_rd = 1'b1; rw_raw = 1'b1;
                alu_raw = alu_op(funct3, instr_id[30]);
            end
            default: ;
        endcase
    end

    assign rs1 = uses_rs1 ? instr_id[19:15] : 5'd0;
    assign rs2 = uses_rs2 ? instr_id[24:20] : 5'd0;
    assign rd  = uses_rd  ? instr_id[11:7]  : 5'd0;

`ifdef DECODE_ILLEGAL_CHECK_EN
    // flag opcodes we do not implement and OP encodings with a bad funct7
    always_comb begin
        illegal_raw = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM: illegal_raw = 1'b0;
            OPC_OP: illegal_raw = !((instr_id[31:25] == 7'h00) ||
                                    ((instr_id[31:25] == 7'h20) &&
                                     ((funct3 == 3'b000) || (funct3 == 3'b101))));
            default: illegal_raw = 1'b1;
        endcase
    end
`else
    assign illegal_raw = 1'b0;
`endif

    assign load_use_stall = valid_id && ex_mem_read && (ex_rd != 5'd0) &&
                            ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));

    // empty or stalled slot goes to EX as a bubble
    assign kill    = !valid_id || load_use_stall || illegal_raw;
    assign illegal = valid_id && !load_use_stall && illegal_raw;

    assign alu_ctrl    = kill ? ALU_ADD : alu_raw;
    assign alu_src_imm = !kill && src_raw;
    assign reg_write   = !kill && rw_raw;
    assign mem_read    = !kill && mr_raw;
    assign mem_write   = !kill && mw_raw;
    assign branch      = !kill && br_raw;
    assign jump        = !kill && j_raw;
    assign jalr        = !kill && jalr_raw;
    assign wb_sel      = kill ? WB_ALU : wb_raw;

endmodule
